// File: rtl/axi4_ram_pkg.sv
// Shared constants, FSM state types and address helpers for the AXI4 RAM responder.
package axi4_ram_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rd_state_t;

   // Reserved burst type 2'b11 is treated like any other illegal burst.
   function automatic logic burst_legal(input logic [2:0] size, input logic [7:0] len,
                                        input logic [1:0] burst);
      logic ok;
      ok = (size <= 3'd2) && (burst != 2'b11);
      if (burst == BURST_WRAP)
         ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      return ok;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
      logic [31:0] incr;
      logic [31:0] mask;
      logic [31:0] res;
      incr = 32'd1 << size;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_FIXED: res = addr;
         BURST_WRAP:  res = (addr & ~mask) | ((addr + incr) & mask);
         default:     res = addr + incr;
      endcase
      return res;
   endfunction

   function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] span);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return !off[32] && (off < span);
   endfunction

endpackage

// File: rtl/axi4_ram_dpram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port.
module axi4_ram_dpram #(
   parameter int WORDS = 1024,
   localparam int AW = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wstrb,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // Same-word read and write in one cycle returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 slave terminating the axiA master port with byte-writable on-chip RAM.
// state   | meaning
// W_IDLE  | awready, waiting for write address
// W_DATA  | wready, accepting beats until beat len+1
// W_RESP  | bvalid held until bready
// R_IDLE  | arready, waiting for read address
// R_FETCH | RAM read issued for current beat address
// R_SEND  | rvalid held until rready
module axi4_ram_responder
   import axi4_ram_pkg::*;
#(
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ID_W      = 8
) (
   input  logic            io_axiClk,
   input  logic            io_axiReset,
   input  logic            axiA_awvalid,
   output logic            axiA_awready,
   input  logic [31:0]     axiA_awaddr,
   input  logic [ID_W-1:0] axiA_awid,
   input  logic [7:0]      axiA_awlen,
   input  logic [2:0]      axiA_awsize,
   input  logic [1:0]      axiA_awburst,
   input  logic [3:0]      axiA_awregion,
   input  logic            axiA_awlock,
   input  logic [3:0]      axiA_awcache,
   input  logic [3:0]      axiA_awqos,
   input  logic [2:0]      axiA_awprot,
   input  logic            axiA_wvalid,
   output logic            axiA_wready,
   input  logic [31:0]     axiA_wdata,
   input  logic [3:0]      axiA_wstrb,
   input  logic            axiA_wlast,
   output logic            axiA_bvalid,
   input  logic            axiA_bready,
   output logic [ID_W-1:0] axiA_bid,
   output logic [1:0]      axiA_bresp,
   input  logic            axiA_arvalid,
   output logic            axiA_arready,
   input  logic [31:0]     axiA_araddr,
   input  logic [ID_W-1:0] axiA_arid,
   input  logic [7:0]      axiA_arlen,
   input  logic [2:0]      axiA_arsize,
   input  logic [1:0]      axiA_arburst,
   input  logic [3:0]      axiA_arregion,
   input  logic            axiA_arlock,
   input  logic [3:0]      axiA_arcache,
   input  logic [3:0]      axiA_arqos,
   input  logic [2:0]      axiA_arprot,
   output logic            axiA_rvalid,
   input  logic            axiA_rready,
   output logic [31:0]     axiA_rdata,
   output logic [ID_W-1:0] axiA_rid,
   output logic [1:0]      axiA_rresp,
   output logic            axiA_rlast
);

   localparam int          AW   = $clog2(MEM_WORDS);
   localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

   logic unused_sideband;
   assign unused_sideband = ^{axiA_awregion, axiA_awlock, axiA_awcache, axiA_awqos, axiA_awprot,
                              axiA_arregion, axiA_arlock, axiA_arcache, axiA_arqos, axiA_arprot};

   wr_state_t       w_state, w_state_nxt;
   logic [31:0]     w_addr;
   logic [ID_W-1:0] w_id;
   logic [7:0]      w_len, w_cnt;
   logic [2:0]      w_size;
   logic [1:0]      w_burst;
   logic            w_err, w_last, w_ok, w_fire;

   rd_state_t       r_state, r_state_nxt;
   logic [31:0]     r_addr;
   logic [ID_W-1:0] r_id;
   logic [7:0]      r_len, r_cnt;
   logic [2:0]      r_size;
   logic [1:0]      r_burst;
   logic            r_last, r_ok, ram_re;
   logic [31:0]     ram_q;

   assign w_last = (w_cnt == w_len);
   assign w_ok   = burst_legal(w_size, w_len, w_burst) && in_range(w_addr, BASE_ADDR, SPAN);
   assign w_fire = axiA_wvalid && axiA_wready;
   assign r_last = (r_cnt == r_len);
   assign r_ok   = burst_legal(r_size, r_len, r_burst) && in_range(r_addr, BASE_ADDR, SPAN);

   always_ff @(posedge io_axiClk) begin
      if (io_axiReset) begin
         w_state <= W_IDLE;
         w_addr  <= '0;
         w_id    <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         if (axiA_awvalid && axiA_awready) begin
            w_addr  <= axiA_awaddr;
            w_id    <= axiA_awid;
            w_len   <= axiA_awlen;
            w_size  <= axiA_awsize;
            w_burst <= axiA_awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
         end
         if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (!w_ok || (axiA_wlast != w_last)) w_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = w_state;
      axiA_awready = 1'b0;
      axiA_wready  = 1'b0;
      axiA_bvalid  = 1'b0;
      axiA_bid     = '0;
      axiA_bresp   = RESP_OKAY;
      if (!io_axiReset) begin
         case (w_state)
            W_IDLE: begin
               axiA_awready = 1'b1;
               if (axiA_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
               axiA_wready = 1'b1;
               if (axiA_wvalid && w_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
               axiA_bvalid = 1'b1;
               axiA_bid    = w_id;
               axiA_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
               if (axiA_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
         endcase
      end
   end

   always_ff @(posedge io_axiClk) begin
      if (io_axiReset) begin
         r_state <= R_IDLE;
         r_addr  <= '0;
         r_id    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
      end else begin
         r_state <= r_state_nxt;
         if (axiA_arvalid && axiA_arready) begin
            r_addr  <= axiA_araddr;
            r_id    <= axiA_arid;
            r_len   <= axiA_arlen;
            r_size  <= axiA_arsize;
            r_burst <= axiA_arburst;
            r_cnt   <= '0;
         end
         if (axiA_rvalid && axiA_rready && !r_last) begin
            r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
            r_cnt  <= r_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      r_state_nxt  = r_state;
      axiA_arready = 1'b0;
      axiA_rvalid  = 1'b0;
      axiA_rdata   = '0;
      axiA_rid     = '0;
      axiA_rresp   = RESP_OKAY;
      axiA_rlast   = 1'b0;
      ram_re       = 1'b0;
      if (!io_axiReset) begin
         case (r_state)
            R_IDLE: begin
               axiA_arready = 1'b1;
               if (axiA_arvalid) r_state_nxt = R_FETCH;
            end
            R_FETCH: begin
               ram_re      = 1'b1;
               r_state_nxt = R_SEND;
            end
            R_SEND: begin
               axiA_rvalid = 1'b1;
               axiA_rid    = r_id;
               axiA_rlast  = r_last;
               axiA_rresp  = r_ok ? RESP_OKAY : RESP_SLVERR;
               axiA_rdata  = r_ok ? ram_q : 32'd0;
               if (axiA_rready) r_state_nxt = r_last ? R_IDLE : R_FETCH;
            end
            default: r_state_nxt = R_IDLE;
         endcase
      end
   end

   axi4_ram_dpram #(.WORDS(MEM_WORDS)) u_ram (
      .clk   (io_axiClk),
      .we    (w_fire && w_ok),
      .waddr (AW'((w_addr - BASE_ADDR) >> 2)),
      .wdata (axiA_wdata),
      .wstrb (axiA_wstrb),
      .re    (ram_re),
      .raddr (AW'((r_addr - BASE_ADDR) >> 2)),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed self-checking bench for axi4_ram_responder.
module tb_axi4_ram_responder;

   localparam int ID_W  = 8;
   localparam int BOUND = 50;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            awvalid = 0, awready;
   logic [31:0]     awaddr = 0;
   logic [ID_W-1:0] awid = 0;
   logic [7:0]      awlen = 0;
   logic [2:0]      awsize = 0;
   logic [1:0]      awburst = 0;
   logic            wvalid = 0, wready;
   logic [31:0]     wdata = 0;
   logic [3:0]      wstrb = 0;
   logic            wlast = 0;
   logic            bvalid, bready = 0;
   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            arvalid = 0, arready;
   logic [31:0]     araddr = 0;
   logic [ID_W-1:0] arid = 0;
   logic [7:0]      arlen = 0;
   logic [2:0]      arsize = 0;
   logic [1:0]      arburst = 0;
   logic            rvalid, rready = 0;
   logic [31:0]     rdata;
   logic [ID_W-1:0] rid;
   logic [1:0]      rresp;
   logic            rlast;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   axi4_ram_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .ID_W(ID_W)) dut (
      .io_axiClk(clk), .io_axiReset(rst),
      .axiA_awvalid(awvalid), .axiA_awready(awready), .axiA_awaddr(awaddr), .axiA_awid(awid),
      .axiA_awlen(awlen), .axiA_awsize(awsize), .axiA_awburst(awburst),
      .axiA_awregion(4'd0), .axiA_awlock(1'b0), .axiA_awcache(4'd0), .axiA_awqos(4'd0),
      .axiA_awprot(3'd0),
      .axiA_wvalid(wvalid), .axiA_wready(wready), .axiA_wdata(wdata), .axiA_wstrb(wstrb),
      .axiA_wlast(wlast),
      .axiA_bvalid(bvalid), .axiA_bready(bready), .axiA_bid(bid), .axiA_bresp(bresp),
      .axiA_arvalid(arvalid), .axiA_arready(arready), .axiA_araddr(araddr), .axiA_arid(arid),
      .axiA_arlen(arlen), .axiA_arsize(arsize), .axiA_arburst(arburst),
      .axiA_arregion(4'd0), .axiA_arlock(1'b0), .axiA_arcache(4'd0), .axiA_arqos(4'd0),
      .axiA_arprot(3'd0),
      .axiA_rvalid(rvalid), .axiA_rready(rready), .axiA_rdata(rdata), .axiA_rid(rid),
      .axiA_rresp(rresp), .axiA_rlast(rlast)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      awvalid = 1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
      while (!awready && n < BOUND) begin tick(); n++; end
      if (!awready) begin
         total++;
         $display("FAIL aw_timeout: awready=%b required 1", awready);
      end
      tick();
      awvalid = 0;
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      arvalid = 1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
      while (!arready && n < BOUND) begin tick(); n++; end
      if (!arready) begin
         total++;
         $display("FAIL ar_timeout: arready=%b required 1", arready);
      end
      tick();
      arvalid = 0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      wvalid = 1; wdata = d; wstrb = s; wlast = l;
      while (!wready && n < BOUND) begin tick(); n++; end
      if (!wready) begin
         total++;
         $display("FAIL w_timeout: wready=%b required 1", wready);
      end
      tick();
      wvalid = 0; wlast = 0;
   endtask

   task automatic b_wait(output logic [1:0] resp, output logic [7:0] id);
      int n = 0;
      bready = 1;
      while (!bvalid && n < BOUND) begin tick(); n++; end
      if (!bvalid) begin
         total++;
         $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
      end
      resp = bresp; id = bid;
      tick();
      bready = 0;
   endtask

   task automatic r_beat(output logic [31:0] d, output logic [1:0] resp, output logic last,
                         output logic [7:0] id, output int waited);
      waited = 0;
      rready = 1;
      while (!rvalid && waited < BOUND) begin tick(); waited++; end
      if (!rvalid) begin
         total++;
         $display("FAIL r_timeout: rvalid=%b required 1", rvalid);
      end
      d = rdata; resp = rresp; last = rlast; id = rid;
      tick();
      rready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) tick();
      total++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0)
         $display("FAIL reset_handshake: got %b required 00000",
                  {awready, wready, bvalid, arready, rvalid});
      else passed++;
      total++;
      if ({bid, bresp, rid, rresp, rdata, rlast} !== '0)
         $display("FAIL reset_payload: got bid=%h bresp=%b rid=%h rresp=%b rdata=%h rlast=%b required all 0",
                  bid, bresp, rid, rresp, rdata, rlast);
      else passed++;
      rst = 0;
      #1;
      total++;
      if ({awready, wready, arready} !== 3'b101)
         $display("FAIL reset_release: got aw/w/ar ready %b required 101", {awready, wready, arready});
      else passed++;
   endtask

   task automatic test_single();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      aw_send(32'h10, 8'h5A, 8'd0, 3'd2, 2'b01);
      w_beat(32'hDEADBEEF, 4'hF, 1'b1);
      total++;
      if (bvalid !== 1'b1) $display("FAIL single_bvalid_timing: got %b required 1", bvalid);
      else passed++;
      b_wait(resp, id);
      total++;
      if ({resp, id} !== {2'b00, 8'h5A})
         $display("FAIL single_bresp: got resp=%b id=%h required resp=00 id=5a", resp, id);
      else passed++;
      ar_send(32'h10, 8'h33, 8'd0, 3'd2, 2'b01);
      r_beat(d, resp, last, id, waited);
      total++;
      if ({d, resp, last, id, waited} !== {32'hDEADBEEF, 2'b00, 1'b1, 8'h33, 32'd1})
         $display("FAIL single_read: got d=%h resp=%b last=%b id=%h wait=%0d required deadbeef 00 1 33 1",
                  d, resp, last, id, waited);
      else passed++;
   endtask

   task automatic test_incr();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      aw_send(32'h20, 8'h01, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
      b_wait(resp, id);
      total++;
      if (resp !== 2'b00) $display("FAIL incr_bresp: got %b required 00", resp);
      else passed++;
      ar_send(32'h20, 8'h02, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) begin
         r_beat(d, resp, last, id, waited);
         total++;
         if ({d, resp, last, waited} !== {32'(i + 1), 2'b00, i == 3, 32'd1})
            $display("FAIL incr_beat%0d: got d=%h resp=%b last=%b wait=%0d required %h 00 %b 1",
                     i, d, resp, last, waited, 32'(i + 1), i == 3);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      logic [31:0] exp_wrap [4];
      exp_wrap = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
      aw_send(32'h30, 8'h03, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), 4'hF, i == 3);
      b_wait(resp, id);
      ar_send(32'h38, 8'h04, 8'd3, 3'd2, 2'b10);
      for (int i = 0; i < 4; i++) begin
         r_beat(d, resp, last, id, waited);
         total++;
         if ({d, resp, last} !== {exp_wrap[i], 2'b00, i == 3})
            $display("FAIL wrap_beat%0d: got d=%h resp=%b last=%b required %h 00 %b",
                     i, d, resp, last, exp_wrap[i], i == 3);
         else passed++;
      end
      ar_send(32'h38, 8'h05, 8'd2, 3'd2, 2'b10);
      for (int i = 0; i < 3; i++) begin
         r_beat(d, resp, last, id, waited);
         total++;
         if ({d, resp, last} !== {32'd0, 2'b10, i == 2})
            $display("FAIL wrap_illegal_beat%0d: got d=%h resp=%b last=%b required 0 10 %b",
                     i, d, resp, last, i == 2);
         else passed++;
      end
   endtask

   task automatic test_strobes_errors();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      aw_send(32'h40, 8'h06, 8'd0, 3'd2, 2'b01);
      w_beat(32'h11223344, 4'hF, 1'b1);
      b_wait(resp, id);
      aw_send(32'h40, 8'h07, 8'd0, 3'd2, 2'b01);
      w_beat(32'hAABBCCDD, 4'b0101, 1'b1);
      b_wait(resp, id);
      ar_send(32'h40, 8'h08, 8'd0, 3'd2, 2'b01);
      r_beat(d, resp, last, id, waited);
      total++;
      if (d !== 32'h11BB33DD) $display("FAIL strobe_merge: got %h required 11bb33dd", d);
      else passed++;

      aw_send(32'h0, 8'h09, 8'd0, 3'd2, 2'b01);
      w_beat(32'h5555AAAA, 4'hF, 1'b1);
      b_wait(resp, id);
      aw_send(32'h1000, 8'h0A, 8'd0, 3'd2, 2'b01);
      w_beat(32'hFFFFFFFF, 4'hF, 1'b1);
      b_wait(resp, id);
      total++;
      if ({resp, id} !== {2'b10, 8'h0A})
         $display("FAIL oor_bresp: got resp=%b id=%h required 10 0a", resp, id);
      else passed++;
      ar_send(32'h0, 8'h0B, 8'd0, 3'd2, 2'b01);
      r_beat(d, resp, last, id, waited);
      total++;
      if (d !== 32'h5555AAAA) $display("FAIL oor_ram_unchanged: got %h required 5555aaaa", d);
      else passed++;
      ar_send(32'h1000, 8'h0C, 8'd0, 3'd2, 2'b01);
      r_beat(d, resp, last, id, waited);
      total++;
      if ({d, resp} !== {32'd0, 2'b10})
         $display("FAIL oor_read: got d=%h resp=%b required 0 10", d, resp);
      else passed++;
      aw_send(32'h44, 8'h0D, 8'd0, 3'd3, 2'b01);
      w_beat(32'h12345678, 4'hF, 1'b1);
      b_wait(resp, id);
      total++;
      if (resp !== 2'b10) $display("FAIL bad_size_bresp: got %b required 10", resp);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      int bad = 0;
      aw_send(32'h50, 8'h21, 8'd0, 3'd2, 2'b01);
      w_beat(32'hCAFEF00D, 4'hF, 1'b1);
      ar_send(32'h20, 8'h3C, 8'd0, 3'd2, 2'b01);
      tick();
      for (int i = 0; i < 5; i++) begin
         if ({bvalid, bid, rvalid, rdata, rid, awready, arready} !==
             {1'b1, 8'h21, 1'b1, 32'd1, 8'h3C, 1'b0, 1'b0}) bad++;
         tick();
      end
      total++;
      if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles required 0", bad);
      else passed++;
      b_wait(resp, id);
      total++;
      if ({resp, id, awready} !== {2'b00, 8'h21, 1'b1})
         $display("FAIL bp_bresp: got resp=%b id=%h awready=%b required 00 21 1", resp, id, awready);
      else passed++;
      r_beat(d, resp, last, id, waited);
      total++;
      if ({d, resp, last, id, waited, arready} !== {32'd1, 2'b00, 1'b1, 8'h3C, 32'd0, 1'b1})
         $display("FAIL bp_read: got d=%h resp=%b last=%b id=%h wait=%0d arready=%b required 1 00 1 3c 0 1",
                  d, resp, last, id, waited, arready);
      else passed++;

      aw_send(32'h60, 8'h22, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(32'(i), 4'hF, (i == 1) || (i == 3));
      b_wait(resp, id);
      total++;
      if (resp !== 2'b10) $display("FAIL early_wlast_bresp: got %b required 10", resp);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [7:0] id; logic [31:0] d; logic last; int waited;
      aw_send(32'h80, 8'h40, 8'd3, 3'd2, 2'b01);
      w_beat(32'h11111111, 4'hF, 1'b0);
      wvalid = 1; wdata = 32'h99999999; wstrb = 4'hF; wlast = 0;
      rst = 1;
      tick();
      total++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0)
         $display("FAIL midreset_outputs: got %b required 00000",
                  {awready, wready, bvalid, arready, rvalid});
      else passed++;
      wvalid = 0;
      tick();
      rst = 0;
      tick();
      total++;
      if ({awready, bvalid} !== 2'b10)
         $display("FAIL midreset_release: got awready/bvalid %b required 10", {awready, bvalid});
      else passed++;
      aw_send(32'h84, 8'h41, 8'd0, 3'd2, 2'b01);
      w_beat(32'h22222222, 4'hF, 1'b1);
      b_wait(resp, id);
      total++;
      if ({resp, id} !== {2'b00, 8'h41})
         $display("FAIL midreset_fresh: got resp=%b id=%h required 00 41", resp, id);
      else passed++;
      ar_send(32'h80, 8'h42, 8'd1, 3'd2, 2'b01);
      r_beat(d, resp, last, id, waited);
      total++;
      if (d !== 32'h11111111) $display("FAIL midreset_kept: got %h required 11111111", d);
      else passed++;
      r_beat(d, resp, last, id, waited);
      total++;
      if ({d, last} !== {32'h22222222, 1'b1})
         $display("FAIL midreset_second: got d=%h last=%b required 22222222 1", d, last);
      else passed++;
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_incr();
      test_wrap();
      test_strobes_errors();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
